// File: rtl/spinet_master.sv
// spinet_master: SPI master pacing WIDTH-bit frames by the node's txready/rxready pins (SPINET_MASTER_POLL_EN adds zero poll frames).
// Latency: frame starts 1 cycle after txr_s/rxr_s is seen; rx_valid rises 1 cycle after the last LOW half-period.
// Backpressure: one-word tx holding register (tx_ready=~tx_full); no frame starts while rx_valid is set.
module spinet_master #(
  parameter int WIDTH  = 16,
  parameter int CLKDIV = 4,
  parameter int GAP    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic             node_txready,
  input  logic             node_rxready,
  output logic             SCLK,
  output logic             SS,
  output logic             MOSI,
  input  logic             MISO,
  output logic             busy
);

  localparam int DMAX = (CLKDIV > GAP) ? CLKDIV : GAP;
  localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0]    DIV_LAST = DW'(CLKDIV - 1);
  // GAP state plus the IDLE decision cycle give GAP cycles of SS high.
  localparam logic [DW-1:0]    GAP_LAST = DW'(GAP - 2);
  localparam logic [DW-1:0]    DIV_ONE  = DW'(1);
  localparam logic [BW-1:0]    BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0]    BIT_ONE  = BW'(1);
  localparam logic [WIDTH-1:0] FULL_BIT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    div;
  logic [BW-1:0]    bitcnt;
  logic [WIDTH-1:0] tx_word, tx_sh, rx_sh;
  logic             tx_full;
  logic             txr_m, txr_s, rxr_m, rxr_s;
  logic             phase_end, start_tx, start_poll, start, poll_go, rx_load;

`ifdef SPINET_MASTER_POLL_EN
  assign poll_go = rxr_s;
`else
  // rxr_s stays referenced so the synchronizer is not flagged as dead logic.
  assign poll_go = 1'b0 & rxr_s;
`endif

  assign start_tx   = (state == S_IDLE) & ~rx_valid & tx_full & txr_s;
  assign start_poll = (state == S_IDLE) & ~rx_valid & ~(tx_full & txr_s) & poll_go;
  assign start      = start_tx | start_poll;
  assign rx_load    = (state == S_LOW) & phase_end & (bitcnt == BIT_LAST) & rx_sh[WIDTH-1];

  always_comb begin
    state_nxt = state;
    phase_end = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SETUP;
      S_SETUP: if (div == DIV_LAST) begin
                 phase_end = 1'b1;
                 state_nxt = S_HIGH;
               end
      S_HIGH:  if (div == DIV_LAST) begin
                 phase_end = 1'b1;
                 state_nxt = S_LOW;
               end
      S_LOW:   if (div == DIV_LAST) begin
                 phase_end = 1'b1;
                 state_nxt = (bitcnt == BIT_LAST) ? S_GAP : S_HIGH;
               end
      S_GAP:   if (div == GAP_LAST) begin
                 phase_end = 1'b1;
                 state_nxt = S_IDLE;
               end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txr_m <= 1'b0;
      txr_s <= 1'b0;
      rxr_m <= 1'b0;
      rxr_s <= 1'b0;
    end else begin
      txr_m <= node_txready;
      txr_s <= txr_m;
      rxr_m <= node_rxready;
      rxr_s <= rxr_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      div    <= '0;
      bitcnt <= '0;
      tx_sh  <= '0;
      rx_sh  <= '0;
    end else begin
      state <= state_nxt;
      div   <= ((state == S_IDLE) || phase_end) ? '0 : div + DIV_ONE;
      if (start)
        bitcnt <= '0;
      else if ((state == S_LOW) && phase_end)
        bitcnt <= bitcnt + BIT_ONE;
      // MOSI advances as SCLK falls; MISO is taken on the last HIGH cycle.
      if (start)
        tx_sh <= start_tx ? tx_word : '0;
      else if ((state == S_HIGH) && phase_end)
        tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
      if ((state == S_HIGH) && phase_end)
        rx_sh <= {rx_sh[WIDTH-2:0], MISO};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_word <= '0;
      tx_full <= 1'b0;
    end else if (tx_valid && !tx_full) begin
      tx_word <= tx_data | FULL_BIT;
      tx_full <= 1'b1;
    end else if (start_tx) begin
      tx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (rx_load) begin
      rx_data  <= rx_sh;
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  assign tx_ready = ~tx_full;
  assign busy     = (state != S_IDLE);
  assign SCLK     = (state == S_HIGH);
  assign SS       = ~((state == S_SETUP) | (state == S_HIGH) | (state == S_LOW));
  assign MOSI     = ~SS & tx_sh[WIDTH-1];

endmodule

// File: tb/tb_spinet_master.sv
// Bench for spinet_master: SPI slave model, frame monitor and word-level expectations.
module tb_spinet_master;
  localparam int W      = 16;
  localparam int CD     = 4;
  localparam int G      = 8;
  localparam int SS_LOW = CD * (1 + 2 * W);

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         node_txready;
  logic         node_rxready;
  logic         SCLK, SS, MOSI, MISO, busy;

  int total = 0;
  int bad   = 0;

  spinet_master #(.WIDTH(W), .CLKDIV(CD), .GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .node_txready(node_txready), .node_rxready(node_rxready),
    .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [W-1:0] fr_mosi[$];
  int           fr_rise[$];
  int           fr_low[$];
  int           fr_gap[$];
  logic [W-1:0] slave_q[$];
  logic [W-1:0] rx_got[$];
  int           frames = 0;

  // Slave model and frame recorder, sampling just after the falling clk edge.
  initial begin
    logic         p_ss, p_sclk, p_mosi;
    logic [W-1:0] mosi_w, miso_sh;
    int           low_cnt, high_cnt, rise_cnt;
    p_ss = 1'b1; p_sclk = 1'b0; p_mosi = 1'b0;
    mosi_w = '0; miso_sh = '0; low_cnt = 0; high_cnt = 0; rise_cnt = 0;
    MISO = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (p_ss && !SS) begin
        low_cnt = 0; rise_cnt = 0; mosi_w = '0;
        fr_gap.push_back(high_cnt);
        miso_sh = (slave_q.size() > 0) ? slave_q.pop_front() : '0;
        MISO = miso_sh[W-1];
      end
      if (!SS) low_cnt++; else high_cnt++;
      if (SCLK && !p_sclk) rise_cnt++;
      if (!SCLK && p_sclk) begin
        mosi_w  = {mosi_w[W-2:0], p_mosi};
        miso_sh = {miso_sh[W-2:0], 1'b0};
        MISO    = miso_sh[W-1];
      end
      if (!p_ss && SS) begin
        high_cnt = 1;
        fr_mosi.push_back(mosi_w);
        fr_rise.push_back(rise_cnt);
        fr_low.push_back(low_cnt);
        frames++;
      end
      if (rx_valid && rx_ready) rx_got.push_back(rx_data);
      p_ss = SS; p_sclk = SCLK; p_mosi = MOSI;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [W-1:0] d);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL push_timeout: tx_ready stayed %0b, required 1 within 2000 cycles", tx_ready);
    end
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tick(1);
    total++;
    if (frames < target) begin
      bad++;
      $display("FAIL frame_timeout: frames=%0d required %0d", frames, target);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
    node_txready = 1'b0; node_rxready = 1'b0;
    tick(3);
    total++;
    if ({SCLK, SS, MOSI, rx_valid, busy, tx_ready} !== 6'b010001) begin
      bad++;
      $display("FAIL reset_outputs: SCLK/SS/MOSI/rx_valid/busy/tx_ready=%b required 010001",
               {SCLK, SS, MOSI, rx_valid, busy, tx_ready});
    end
    total++;
    if (rx_data !== '0) begin
      bad++;
      $display("FAIL reset_rx_data: got %h required 0000", rx_data);
    end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_single;
    int base;
    node_txready = 1'b1;
    tick(4);
    base = frames;
    slave_q.push_back('0);
    tx_data = 16'h1234; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    total++;
    if (tx_ready !== 1'b0 || SS !== 1'b1) begin
      bad++;
      $display("FAIL single_held: tx_ready=%b SS=%b required 0 1", tx_ready, SS);
    end
    @(negedge clk);
    total++;
    if (SS !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_start: SS=%b tx_ready=%b busy=%b required 0 1 1", SS, tx_ready, busy);
    end
    wait_frames(base + 1);
    total++;
    if (fr_mosi[base] !== 16'h9234) begin
      bad++;
      $display("FAIL single_mosi: got %h required 9234", fr_mosi[base]);
    end
    total++;
    if (fr_low[base] != SS_LOW || fr_rise[base] != W) begin
      bad++;
      $display("FAIL single_shape: ss_low=%0d rises=%0d required %0d %0d",
               fr_low[base], fr_rise[base], SS_LOW, W);
    end
    total++;
    if (rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_no_rx: rx_valid=%b required 0", rx_valid);
    end
  endtask

  task automatic test_backpressure;
    int base, lows, n;
    logic [W-1:0] w;
    node_txready = 1'b0;
    tick(4);
    base = frames;
    w = 16'($urandom);
    push_tx(w);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (!SS) lows++;
    end
    total++;
    if (lows != 0 || tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_hold: ss_low_cycles=%0d tx_ready=%b required 0 0", lows, tx_ready);
    end
    node_txready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (SS && n < 20);
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL bp_latency: frame started after %0d cycles required 3", n);
    end
    wait_frames(base + 1);
    total++;
    if (fr_mosi[base] !== (w | 16'h8000)) begin
      bad++;
      $display("FAIL bp_mosi: got %h required %h", fr_mosi[base], w | 16'h8000);
    end
  endtask

  task automatic test_rx_stall;
    int base, lows, rxb;
    logic [W-1:0] a, b, m;
    rx_ready = 1'b0; node_txready = 1'b1;
    a = 16'($urandom); b = 16'($urandom); m = 16'($urandom) | 16'h8000;
    base = frames;
    slave_q.push_back(m);
    push_tx(a);
    wait_frames(base + 1);
    tick(2);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== m) begin
      bad++;
      $display("FAIL stall_rx: rx_valid=%b rx_data=%h required 1 %h", rx_valid, rx_data, m);
    end
    slave_q.push_back('0);
    push_tx(b);
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      if (!SS) lows++;
    end
    total++;
    if (lows != 0) begin
      bad++;
      $display("FAIL stall_block: ss_low_cycles=%0d required 0", lows);
    end
    rxb = rx_got.size();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    total++;
    if (rx_valid !== 1'b0 || SS !== 1'b1) begin
      bad++;
      $display("FAIL stall_consume: rx_valid=%b SS=%b required 0 1", rx_valid, SS);
    end
    @(negedge clk);
    total++;
    if (SS !== 1'b0) begin
      bad++;
      $display("FAIL stall_restart: SS=%b required 0", SS);
    end
    wait_frames(base + 2);
    total++;
    if (rx_got.size() != rxb + 1 || fr_mosi[base + 1] !== (b | 16'h8000)) begin
      bad++;
      $display("FAIL stall_result: rx_count=%0d mosi=%h required %0d %h",
               rx_got.size() - rxb, fr_mosi[base + 1], 1, b | 16'h8000);
    end else begin
      total++;
      if (rx_got[rxb] !== m) begin
        bad++;
        $display("FAIL stall_rx_word: got %h required %h", rx_got[rxb], m);
      end
    end
    rx_ready = 1'b1;
  endtask

`ifdef SPINET_MASTER_POLL_EN
  task automatic test_poll;
    int base, n;
    rx_ready = 1'b0;
    base = frames;
    slave_q.push_back(16'hC5A5);
    node_rxready = 1'b1;
    n = 0;
    while (SS && n < 50) begin
      @(negedge clk);
      n++;
    end
    node_rxready = 1'b0;
    wait_frames(base + 1);
    tick(2);
    total++;
    if (fr_mosi[base] !== '0 || rx_valid !== 1'b1 || rx_data !== 16'hC5A5) begin
      bad++;
      $display("FAIL poll_data: mosi=%h rx_valid=%b rx_data=%h required 0000 1 c5a5",
               fr_mosi[base], rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    tick(2);
    base = frames;
    node_rxready = 1'b1;
    n = 0;
    while (SS && n < 50) begin
      @(negedge clk);
      n++;
    end
    node_rxready = 1'b0;
    wait_frames(base + 1);
    tick(200);
    total++;
    if (rx_valid !== 1'b0 || fr_mosi[base] !== '0 || frames != base + 1) begin
      bad++;
      $display("FAIL poll_zero: rx_valid=%b mosi=%h frames=%0d required 0 0000 %0d",
               rx_valid, fr_mosi[base], frames - base, 1);
    end
  endtask
`else
  task automatic test_poll;
    int lows;
    rx_ready = 1'b1;
    node_rxready = 1'b1;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (!SS) lows++;
    end
    node_rxready = 1'b0;
    total++;
    if (lows != 0) begin
      bad++;
      $display("FAIL poll_disabled: ss_low_cycles=%0d required 0", lows);
    end
  endtask
`endif

  task automatic run_words(input string name, input int cnt, input bit spaced);
    int base, rxb, k;
    logic [W-1:0] exp_mosi[$];
    logic [W-1:0] exp_rx[$];
    logic [W-1:0] w, m;
    rx_ready = 1'b1; node_txready = 1'b1;
    tick(4);
    base = frames;
    rxb = rx_got.size();
    for (int i = 0; i < cnt; i++) begin
      w = 16'($urandom);
      m = 16'($urandom);
      exp_mosi.push_back(w | 16'h8000);
      if (m[W-1]) exp_rx.push_back(m);
      slave_q.push_back(m);
      push_tx(w);
      if (spaced) tick($urandom_range(0, 200));
    end
    wait_frames(base + cnt);
    for (int i = 0; i < cnt; i++) begin
      total++;
      if (fr_mosi[base + i] !== exp_mosi[i] || fr_rise[base + i] != W || fr_low[base + i] != SS_LOW) begin
        bad++;
        $display("FAIL %s_frame%0d: mosi=%h rises=%0d ss_low=%0d required %h %0d %0d", name, i,
                 fr_mosi[base + i], fr_rise[base + i], fr_low[base + i], exp_mosi[i], W, SS_LOW);
      end
      if (!spaced && i > 0) begin
        total++;
        if (fr_gap[base + i] != G) begin
          bad++;
          $display("FAIL %s_gap%0d: ss_high=%0d required %0d", name, i, fr_gap[base + i], G);
        end
      end
    end
    total++;
    if (rx_got.size() - rxb != exp_rx.size()) begin
      bad++;
      $display("FAIL %s_rx_count: got %0d required %0d", name, rx_got.size() - rxb, exp_rx.size());
    end else begin
      k = 0;
      foreach (exp_rx[i]) begin
        if (rx_got[rxb + i] !== exp_rx[i]) k++;
      end
      total++;
      if (k != 0) begin
        bad++;
        $display("FAIL %s_rx_words: %0d words differ, required 0", name, k);
      end
    end
  endtask

  task automatic test_back_to_back;
    run_words("b2b", 3, 1'b0);
  endtask

  task automatic test_random;
    run_words("rand", 6, 1'b1);
  endtask

  task automatic test_reset_midframe;
    int n, rises;
    logic p;
    node_txready = 1'b1;
    tick(4);
    push_tx(16'($urandom));
    tx_data = 16'($urandom); tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (!SCLK && n < 50) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({SCLK, SS, MOSI, busy, tx_ready, rx_valid} !== 6'b010010) begin
      bad++;
      $display("FAIL midframe_reset: SCLK/SS/MOSI/busy/tx_ready/rx_valid=%b required 010010",
               {SCLK, SS, MOSI, busy, tx_ready, rx_valid});
    end
    tick(2);
    rst_n = 1'b1;
    rises = 0;
    p = SCLK;
    repeat (300) begin
      @(negedge clk);
      if (SCLK && !p) rises++;
      p = SCLK;
    end
    total++;
    if (rises != 0 || SS !== 1'b1) begin
      bad++;
      $display("FAIL midframe_after: sclk_rises=%0d SS=%b required 0 1", rises, SS);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_rx_stall();
    test_poll();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
